// File: rtl/icache_miss_handler.sv
// rtl/icache_miss_handler.sv - I-cache miss controller: victim-cache probe, L2 fetch, refill and evict push.
// Optional MISS_HANDLER_PERF_EN adds saturating VC-hit and L2-fetch counters.
module icache_miss_handler #(
   parameter int BLOCK_WIDTH = 512,
   parameter int TAG_WIDTH   = 26,
   parameter int VC_LATENCY  = 2
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   MISS_VALID,
   input  logic [TAG_WIDTH-1:0]   MISS_TAG,
   input  logic                   EVICT_VALID,
   input  logic [TAG_WIDTH-1:0]   EVICT_TAG,
   input  logic [BLOCK_WIDTH-1:0] EVICT_DATA,
   output logic                   MISS_READY,
   output logic                   REFILL_VALID,
   output logic [TAG_WIDTH-1:0]   REFILL_TAG,
   output logic [BLOCK_WIDTH-1:0] REFILL_DATA,
   output logic                   REFILL_FROM_VC,
   output logic [TAG_WIDTH-1:0]   VC_WRITE_TAG_ADDRESS,
   output logic [BLOCK_WIDTH-1:0] VC_WRITE_DATA,
   output logic                   VC_WRITE_ENABLE,
   output logic [TAG_WIDTH-1:0]   VC_READ_TAG_ADDRESS,
   output logic                   VC_READ_ENABLE,
   input  logic                   VC_READ_HIT,
   input  logic [BLOCK_WIDTH-1:0] VC_READ_DATA,
   output logic                   L2_REQ_VALID,
   output logic [TAG_WIDTH-1:0]   L2_REQ_TAG,
   input  logic                   L2_REQ_READY,
   input  logic                   L2_RESP_VALID,
   input  logic [BLOCK_WIDTH-1:0] L2_RESP_DATA
`ifdef MISS_HANDLER_PERF_EN
   ,
   output logic [31:0]            VC_HIT_COUNT,
   output logic [31:0]            L2_FETCH_COUNT
`endif
);

   localparam int CNT_W = (VC_LATENCY > 1) ? $clog2(VC_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAST_PROBE = CNT_W'(VC_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PROBE,
      S_CHECK,
      S_L2_REQ,
      S_L2_WAIT,
      S_REFILL
   } state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_probe_cnt;
   logic [TAG_WIDTH-1:0]   r_miss_tag;
   logic                   r_evict_valid;
   logic [TAG_WIDTH-1:0]   r_evict_tag;
   logic [BLOCK_WIDTH-1:0] r_evict_data;
   logic [BLOCK_WIDTH-1:0] r_fill_data;
   logic                   r_from_vc;
   logic                   r_miss_ready;
   logic                   r_refill_valid;
   logic                   r_vc_read_en;
   logic                   r_vc_write_en;
   logic                   r_l2_req_valid;
`ifdef MISS_HANDLER_PERF_EN
   logic [31:0]            r_vc_hit_cnt;
   logic [31:0]            r_l2_fetch_cnt;
`endif

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state        <= S_IDLE;
         r_probe_cnt    <= '0;
         r_miss_tag     <= '0;
         r_evict_valid  <= 1'b0;
         r_evict_tag    <= '0;
         r_evict_data   <= '0;
         r_fill_data    <= '0;
         r_from_vc      <= 1'b0;
         r_miss_ready   <= 1'b1;
         r_refill_valid <= 1'b0;
         r_vc_read_en   <= 1'b0;
         r_vc_write_en  <= 1'b0;
         r_l2_req_valid <= 1'b0;
`ifdef MISS_HANDLER_PERF_EN
         r_vc_hit_cnt   <= '0;
         r_l2_fetch_cnt <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (MISS_VALID) begin
                  r_miss_tag    <= MISS_TAG;
                  r_evict_valid <= EVICT_VALID;
                  r_evict_tag   <= EVICT_TAG;
                  r_evict_data  <= EVICT_DATA;
                  r_from_vc     <= 1'b0;
                  r_probe_cnt   <= '0;
                  r_miss_ready  <= 1'b0;
                  r_vc_read_en  <= 1'b1;
                  r_state       <= S_PROBE;
               end
            end
            // Read enable stays high across the whole probe so a pipelined VC output can advance.
            S_PROBE: begin
               if (r_probe_cnt == LAST_PROBE) begin
                  r_vc_read_en <= 1'b0;
                  r_state      <= S_CHECK;
               end else begin
                  r_probe_cnt <= r_probe_cnt + CNT_W'(1);
               end
            end
            S_CHECK: begin
               if (VC_READ_HIT) begin
                  r_fill_data    <= VC_READ_DATA;
                  r_from_vc      <= 1'b1;
                  r_refill_valid <= 1'b1;
                  r_vc_write_en  <= r_evict_valid;
                  r_state        <= S_REFILL;
`ifdef MISS_HANDLER_PERF_EN
                  if (r_vc_hit_cnt != '1) r_vc_hit_cnt <= r_vc_hit_cnt + 32'd1;
`endif
               end else begin
                  r_l2_req_valid <= 1'b1;
                  r_state        <= S_L2_REQ;
               end
            end
            S_L2_REQ: begin
               if (L2_REQ_READY) begin
                  r_l2_req_valid <= 1'b0;
                  r_state        <= S_L2_WAIT;
`ifdef MISS_HANDLER_PERF_EN
                  if (r_l2_fetch_cnt != '1) r_l2_fetch_cnt <= r_l2_fetch_cnt + 32'd1;
`endif
               end
            end
            S_L2_WAIT: begin
               if (L2_RESP_VALID) begin
                  r_fill_data    <= L2_RESP_DATA;
                  r_from_vc      <= 1'b0;
                  r_refill_valid <= 1'b1;
                  r_vc_write_en  <= r_evict_valid;
                  r_state        <= S_REFILL;
               end
            end
            // The evict push lands here, after the lookup, so it can never satisfy its own miss.
            S_REFILL: begin
               r_refill_valid <= 1'b0;
               r_vc_write_en  <= 1'b0;
               r_from_vc      <= 1'b0;
               r_miss_ready   <= 1'b1;
               r_state        <= S_IDLE;
            end
            default: begin
               r_refill_valid <= 1'b0;
               r_vc_write_en  <= 1'b0;
               r_vc_read_en   <= 1'b0;
               r_l2_req_valid <= 1'b0;
               r_miss_ready   <= 1'b1;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

   assign MISS_READY           = r_miss_ready;
   assign REFILL_VALID         = r_refill_valid;
   assign REFILL_TAG           = r_refill_valid ? r_miss_tag : '0;
   assign REFILL_DATA          = r_refill_valid ? r_fill_data : '0;
   assign REFILL_FROM_VC       = r_refill_valid & r_from_vc;
   assign VC_WRITE_ENABLE      = r_vc_write_en;
   assign VC_WRITE_TAG_ADDRESS = r_vc_write_en ? r_evict_tag : '0;
   assign VC_WRITE_DATA        = r_vc_write_en ? r_evict_data : '0;
   assign VC_READ_ENABLE       = r_vc_read_en;
   assign VC_READ_TAG_ADDRESS  = r_vc_read_en ? r_miss_tag : '0;
   assign L2_REQ_VALID         = r_l2_req_valid;
   assign L2_REQ_TAG           = r_l2_req_valid ? r_miss_tag : '0;
`ifdef MISS_HANDLER_PERF_EN
   assign VC_HIT_COUNT         = r_vc_hit_cnt;
   assign L2_FETCH_COUNT       = r_l2_fetch_cnt;
`endif

endmodule

// File: tb/tb_icache_miss_handler.sv
// tb/tb_icache_miss_handler.sv - directed self-checking bench for icache_miss_handler.
// Perf counter checks are compiled in when MISS_HANDLER_PERF_EN is defined.
module tb_icache_miss_handler;

   localparam int BW = 512;
   localparam int TW = 26;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          MISS_VALID, m1_valid;
   logic [TW-1:0] MISS_TAG;
   logic          EVICT_VALID;
   logic [TW-1:0] EVICT_TAG;
   logic [BW-1:0] EVICT_DATA;
   logic          VC_READ_HIT;
   logic [BW-1:0] VC_READ_DATA;
   logic          L2_REQ_READY, L2_RESP_VALID;
   logic [BW-1:0] L2_RESP_DATA;

   logic          MISS_READY, REFILL_VALID, REFILL_FROM_VC;
   logic [TW-1:0] REFILL_TAG, VC_WRITE_TAG_ADDRESS, VC_READ_TAG_ADDRESS, L2_REQ_TAG;
   logic [BW-1:0] REFILL_DATA, VC_WRITE_DATA;
   logic          VC_WRITE_ENABLE, VC_READ_ENABLE, L2_REQ_VALID;

   logic          d1_miss_ready, d1_refill_valid, d1_from_vc;
   logic [TW-1:0] d1_refill_tag, d1_wtag, d1_rtag, d1_l2tag;
   logic [BW-1:0] d1_refill_data, d1_wdata;
   logic          d1_wen, d1_ren, d1_l2v;
`ifdef MISS_HANDLER_PERF_EN
   logic [31:0]   hit_cnt, fetch_cnt, d1_hit_cnt, d1_fetch_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [BW-1:0] pat_a5, pat_5a, pat_3c, pat_b7, pat_c3;

   always #5 CLK = ~CLK;

   icache_miss_handler #(.BLOCK_WIDTH(BW), .TAG_WIDTH(TW), .VC_LATENCY(2)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .MISS_VALID(MISS_VALID), .MISS_TAG(MISS_TAG),
      .EVICT_VALID(EVICT_VALID), .EVICT_TAG(EVICT_TAG), .EVICT_DATA(EVICT_DATA),
      .MISS_READY(MISS_READY),
      .REFILL_VALID(REFILL_VALID), .REFILL_TAG(REFILL_TAG), .REFILL_DATA(REFILL_DATA),
      .REFILL_FROM_VC(REFILL_FROM_VC),
      .VC_WRITE_TAG_ADDRESS(VC_WRITE_TAG_ADDRESS), .VC_WRITE_DATA(VC_WRITE_DATA),
      .VC_WRITE_ENABLE(VC_WRITE_ENABLE),
      .VC_READ_TAG_ADDRESS(VC_READ_TAG_ADDRESS), .VC_READ_ENABLE(VC_READ_ENABLE),
      .VC_READ_HIT(VC_READ_HIT), .VC_READ_DATA(VC_READ_DATA),
      .L2_REQ_VALID(L2_REQ_VALID), .L2_REQ_TAG(L2_REQ_TAG), .L2_REQ_READY(L2_REQ_READY),
      .L2_RESP_VALID(L2_RESP_VALID), .L2_RESP_DATA(L2_RESP_DATA)
`ifdef MISS_HANDLER_PERF_EN
      , .VC_HIT_COUNT(hit_cnt), .L2_FETCH_COUNT(fetch_cnt)
`endif
   );

   icache_miss_handler #(.BLOCK_WIDTH(BW), .TAG_WIDTH(TW), .VC_LATENCY(1)) dut1 (
      .CLK(CLK), .RSTN(RSTN),
      .MISS_VALID(m1_valid), .MISS_TAG(MISS_TAG),
      .EVICT_VALID(EVICT_VALID), .EVICT_TAG(EVICT_TAG), .EVICT_DATA(EVICT_DATA),
      .MISS_READY(d1_miss_ready),
      .REFILL_VALID(d1_refill_valid), .REFILL_TAG(d1_refill_tag), .REFILL_DATA(d1_refill_data),
      .REFILL_FROM_VC(d1_from_vc),
      .VC_WRITE_TAG_ADDRESS(d1_wtag), .VC_WRITE_DATA(d1_wdata), .VC_WRITE_ENABLE(d1_wen),
      .VC_READ_TAG_ADDRESS(d1_rtag), .VC_READ_ENABLE(d1_ren),
      .VC_READ_HIT(VC_READ_HIT), .VC_READ_DATA(VC_READ_DATA),
      .L2_REQ_VALID(d1_l2v), .L2_REQ_TAG(d1_l2tag), .L2_REQ_READY(L2_REQ_READY),
      .L2_RESP_VALID(L2_RESP_VALID), .L2_RESP_DATA(L2_RESP_DATA)
`ifdef MISS_HANDLER_PERF_EN
      , .VC_HIT_COUNT(d1_hit_cnt), .L2_FETCH_COUNT(d1_fetch_cnt)
`endif
   );

   logic w_any_out;
   assign w_any_out = |{REFILL_VALID, REFILL_TAG, REFILL_DATA, REFILL_FROM_VC,
                        VC_WRITE_TAG_ADDRESS, VC_WRITE_DATA, VC_WRITE_ENABLE,
                        VC_READ_TAG_ADDRESS, VC_READ_ENABLE, L2_REQ_VALID, L2_REQ_TAG};

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue_miss(input logic [TW-1:0] tag, input logic ev,
                             input logic [TW-1:0] etag, input logic [BW-1:0] edata);
      int n = 0;
      while (MISS_READY !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      n_vec++;
      if (MISS_READY !== 1'b1) begin
         $display("FAIL issue_ready: MISS_READY=%b required 1", MISS_READY);
         n_err++;
      end
      MISS_VALID  = 1'b1;
      MISS_TAG    = tag;
      EVICT_VALID = ev;
      EVICT_TAG   = etag;
      EVICT_DATA  = edata;
      step();
      MISS_VALID  = 1'b0;
      EVICT_VALID = 1'b0;
   endtask

   task automatic wait_refill(input logic exp_vc);
      int n = 0;
      while (REFILL_VALID !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      n_vec++;
      if (REFILL_VALID !== 1'b1) begin
         $display("FAIL refill_timeout: REFILL_VALID=%b required 1", REFILL_VALID);
         n_err++;
      end else begin
         n_vec++;
         if (REFILL_FROM_VC !== exp_vc) begin
            $display("FAIL refill_src: REFILL_FROM_VC=%b required %b", REFILL_FROM_VC, exp_vc);
            n_err++;
         end
      end
      step();
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      step();
      step();
      n_vec++;
      if (w_any_out !== 1'b0 || MISS_READY !== 1'b1) begin
         $display("FAIL reset_hold: any_out=%b ready=%b required 0/1", w_any_out, MISS_READY);
         n_err++;
      end
      RSTN = 1'b1;
      step();
      n_vec++;
      if (w_any_out !== 1'b0 || MISS_READY !== 1'b1 || d1_miss_ready !== 1'b1) begin
         $display("FAIL reset_idle: any_out=%b ready=%b d1_ready=%b required 0/1/1",
                  w_any_out, MISS_READY, d1_miss_ready);
         n_err++;
      end
   endtask

   task automatic test_vc_hit();
      VC_READ_HIT  = 1'b1;
      VC_READ_DATA = pat_a5;
      issue_miss(26'h0000ABC, 1'b0, '0, '0);
      for (int c = 1; c <= 6; c++) begin
         n_vec++;
         if (VC_READ_ENABLE !== (c == 1 || c == 2)) begin
            $display("FAIL hit_rd_en c%0d: VC_READ_ENABLE=%b required %b", c, VC_READ_ENABLE, (c == 1 || c == 2));
            n_err++;
         end
         if (c <= 2) begin
            n_vec++;
            if (VC_READ_TAG_ADDRESS !== 26'h0000ABC) begin
               $display("FAIL hit_rd_tag c%0d: tag=%h required 0000abc", c, VC_READ_TAG_ADDRESS);
               n_err++;
            end
         end
         n_vec++;
         if (REFILL_VALID !== (c == 4) || L2_REQ_VALID !== 1'b0) begin
            $display("FAIL hit_refill c%0d: REFILL_VALID=%b L2_REQ_VALID=%b required %b/0",
                     c, REFILL_VALID, L2_REQ_VALID, (c == 4));
            n_err++;
         end
         if (c == 4) begin
            n_vec++;
            if (REFILL_FROM_VC !== 1'b1 || REFILL_TAG !== 26'h0000ABC || REFILL_DATA !== pat_a5) begin
               $display("FAIL hit_payload: from_vc=%b tag=%h data=%h", REFILL_FROM_VC, REFILL_TAG, REFILL_DATA);
               n_err++;
            end
         end
         step();
      end
   endtask

   task automatic test_l2_fetch();
      VC_READ_HIT  = 1'b0;
      L2_REQ_READY = 1'b0;
      issue_miss(26'h0000123, 1'b0, '0, '0);
      for (int c = 1; c <= 14; c++) begin
         L2_REQ_READY  = (c == 7);
         L2_RESP_VALID = (c == 12);
         L2_RESP_DATA  = (c == 12) ? pat_5a : '0;
         n_vec++;
         if (L2_REQ_VALID !== (c >= 4 && c <= 7)) begin
            $display("FAIL l2_req_valid c%0d: L2_REQ_VALID=%b required %b", c, L2_REQ_VALID, (c >= 4 && c <= 7));
            n_err++;
         end
         if (c >= 4 && c <= 7) begin
            n_vec++;
            if (L2_REQ_TAG !== 26'h0000123) begin
               $display("FAIL l2_req_tag c%0d: tag=%h required 0000123", c, L2_REQ_TAG);
               n_err++;
            end
         end
         n_vec++;
         if (REFILL_VALID !== (c == 13) || VC_READ_ENABLE !== (c == 1 || c == 2)) begin
            $display("FAIL l2_timeline c%0d: REFILL_VALID=%b VC_READ_ENABLE=%b", c, REFILL_VALID, VC_READ_ENABLE);
            n_err++;
         end
         if (c == 13) begin
            n_vec++;
            if (REFILL_FROM_VC !== 1'b0 || REFILL_TAG !== 26'h0000123 || REFILL_DATA !== pat_5a) begin
               $display("FAIL l2_payload: from_vc=%b tag=%h data=%h", REFILL_FROM_VC, REFILL_TAG, REFILL_DATA);
               n_err++;
            end
         end
         step();
      end
      L2_REQ_READY  = 1'b0;
      L2_RESP_VALID = 1'b0;
   endtask

   task automatic test_evict();
      VC_READ_HIT  = 1'b1;
      VC_READ_DATA = pat_b7;
      for (int pass = 0; pass < 2; pass++) begin
         issue_miss(26'h0000055, (pass == 0), 26'h0000777, pat_3c);
         for (int c = 1; c <= 5; c++) begin
            n_vec++;
            if (VC_WRITE_ENABLE !== (pass == 0 && c == 4)) begin
               $display("FAIL evict_wen p%0d c%0d: VC_WRITE_ENABLE=%b required %b",
                        pass, c, VC_WRITE_ENABLE, (pass == 0 && c == 4));
               n_err++;
            end
            n_vec++;
            if (VC_WRITE_ENABLE === 1'b1 && VC_READ_ENABLE === 1'b1) begin
               $display("FAIL evict_overlap p%0d c%0d: write and read enable both 1", pass, c);
               n_err++;
            end
            if (pass == 0 && c == 4) begin
               n_vec++;
               if (REFILL_VALID !== 1'b1 || VC_WRITE_TAG_ADDRESS !== 26'h0000777 || VC_WRITE_DATA !== pat_3c) begin
                  $display("FAIL evict_payload: refill=%b wtag=%h wdata=%h required 1/0000777/3c..",
                           REFILL_VALID, VC_WRITE_TAG_ADDRESS, VC_WRITE_DATA);
                  n_err++;
               end
            end
            if (pass == 1) begin
               n_vec++;
               if (VC_WRITE_TAG_ADDRESS !== '0) begin
                  $display("FAIL evict_none_tag c%0d: wtag=%h required 0", c, VC_WRITE_TAG_ADDRESS);
                  n_err++;
               end
            end
            step();
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] tag2;
      tag2         = 26'h0000205;
      VC_READ_HIT  = 1'b1;
      VC_READ_DATA = pat_b7;
      MISS_VALID   = 1'b1;
      MISS_TAG     = 26'h0000111;
      step();
      for (int c = 1; c <= 9; c++) begin
         if (c <= 5) MISS_TAG = 26'h0000200 + TW'(c);
         if (c == 6) MISS_VALID = 1'b0;
         n_vec++;
         if (MISS_READY !== (c == 5)) begin
            $display("FAIL b2b_ready c%0d: MISS_READY=%b required %b", c, MISS_READY, (c == 5));
            n_err++;
         end
         n_vec++;
         if (VC_READ_ENABLE !== (c == 1 || c == 2 || c == 6 || c == 7)) begin
            $display("FAIL b2b_rd_en c%0d: VC_READ_ENABLE=%b", c, VC_READ_ENABLE);
            n_err++;
         end
         if (VC_READ_ENABLE === 1'b1) begin
            n_vec++;
            if (VC_READ_TAG_ADDRESS !== ((c <= 2) ? 26'h0000111 : tag2)) begin
               $display("FAIL b2b_rd_tag c%0d: tag=%h", c, VC_READ_TAG_ADDRESS);
               n_err++;
            end
         end
         n_vec++;
         if (REFILL_VALID !== (c == 4 || c == 9)) begin
            $display("FAIL b2b_refill c%0d: REFILL_VALID=%b required %b", c, REFILL_VALID, (c == 4 || c == 9));
            n_err++;
         end
         if (c == 4 || c == 9) begin
            n_vec++;
            if (REFILL_TAG !== ((c == 4) ? 26'h0000111 : tag2)) begin
               $display("FAIL b2b_refill_tag c%0d: tag=%h", c, REFILL_TAG);
               n_err++;
            end
         end
         step();
      end
   endtask

   task automatic test_reset_mid_miss();
      VC_READ_HIT  = 1'b0;
      L2_REQ_READY = 1'b1;
      issue_miss(26'h00002AB, 1'b1, 26'h0000001, pat_3c);
      for (int c = 1; c < 5; c++) step();
      L2_REQ_READY = 1'b0;
      n_vec++;
      if (MISS_READY !== 1'b0 || L2_REQ_VALID !== 1'b0) begin
         $display("FAIL rst_pre_wait: ready=%b l2v=%b required 0/0", MISS_READY, L2_REQ_VALID);
         n_err++;
      end
      #2;
      RSTN = 1'b0;
      #1;
      n_vec++;
      if (w_any_out !== 1'b0 || MISS_READY !== 1'b1) begin
         $display("FAIL rst_async: any_out=%b ready=%b required 0/1", w_any_out, MISS_READY);
         n_err++;
      end
      @(negedge CLK);
      RSTN = 1'b1;
      step();
      L2_RESP_VALID = 1'b1;
      L2_RESP_DATA  = pat_5a;
      step();
      L2_RESP_VALID = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if (w_any_out !== 1'b0 || MISS_READY !== 1'b1) begin
            $display("FAIL rst_stray_resp c%0d: any_out=%b refill=%b ready=%b", c, w_any_out, REFILL_VALID, MISS_READY);
            n_err++;
         end
         step();
      end
   endtask

   task automatic test_low_latency();
      VC_READ_HIT  = 1'b1;
      VC_READ_DATA = pat_c3;
      MISS_TAG     = 26'h000003E;
      m1_valid     = 1'b1;
      step();
      m1_valid     = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         n_vec++;
         if (d1_ren !== (c == 1) || d1_refill_valid !== (c == 3)) begin
            $display("FAIL lat1 c%0d: rd_en=%b refill=%b required %b/%b", c, d1_ren, d1_refill_valid, (c == 1), (c == 3));
            n_err++;
         end
         if (c == 3) begin
            n_vec++;
            if (d1_from_vc !== 1'b1 || d1_refill_data !== pat_c3 || d1_refill_tag !== 26'h000003E) begin
               $display("FAIL lat1_payload: from_vc=%b tag=%h", d1_from_vc, d1_refill_tag);
               n_err++;
            end
         end
         step();
      end
   endtask

   task automatic test_perf();
      RSTN = 1'b0;
      step();
      RSTN = 1'b1;
      step();
      VC_READ_HIT  = 1'b1;
      VC_READ_DATA = pat_a5;
      issue_miss(26'h0000010, 1'b0, '0, '0);
      wait_refill(1'b1);
      issue_miss(26'h0000011, 1'b0, '0, '0);
      wait_refill(1'b1);
      VC_READ_HIT   = 1'b0;
      L2_REQ_READY  = 1'b1;
      L2_RESP_VALID = 1'b1;
      L2_RESP_DATA  = pat_5a;
      issue_miss(26'h0000012, 1'b0, '0, '0);
      wait_refill(1'b0);
      L2_REQ_READY  = 1'b0;
      L2_RESP_VALID = 1'b0;
`ifdef MISS_HANDLER_PERF_EN
      n_vec++;
      if (hit_cnt !== 32'd2 || fetch_cnt !== 32'd1) begin
         $display("FAIL perf_counts: VC_HIT_COUNT=%0d L2_FETCH_COUNT=%0d required 2/1", hit_cnt, fetch_cnt);
         n_err++;
      end
`endif
   endtask

   initial begin
      pat_a5 = {64{8'hA5}};
      pat_5a = {64{8'h5A}};
      pat_3c = {64{8'h3C}};
      pat_b7 = {64{8'hB7}};
      pat_c3 = {64{8'hC3}};
      RSTN = 1'b0;
      MISS_VALID = 1'b0;
      m1_valid = 1'b0;
      MISS_TAG = '0;
      EVICT_VALID = 1'b0;
      EVICT_TAG = '0;
      EVICT_DATA = '0;
      VC_READ_HIT = 1'b0;
      VC_READ_DATA = '0;
      L2_REQ_READY = 1'b0;
      L2_RESP_VALID = 1'b0;
      L2_RESP_DATA = '0;
      #1;
      test_reset();
      test_vc_hit();
      test_l2_fetch();
      test_evict();
      test_back_to_back();
      test_reset_mid_miss();
      test_low_latency();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
